// File: rtl/wisc_pkg.sv
// Shared WISC types: opcodes, branch condition codes, flag register layout.
package wisc_pkg;

    localparam int unsigned DW  = 16;
    localparam int unsigned OPW = 4;
    localparam int unsigned CCW = 3;

    typedef enum logic [3:0] {
        OP_ADD    = 4'b0000,
        OP_SUB    = 4'b0001,
        OP_XOR    = 4'b0010,
        OP_RED    = 4'b0011,
        OP_SLL    = 4'b0100,
        OP_SRA    = 4'b0101,
        OP_ROR    = 4'b0110,
        OP_PADDSB = 4'b0111
    } opcode_t;

    typedef enum logic [2:0] {
        CC_NEQ    = 3'b000,
        CC_EQ     = 3'b001,
        CC_GT     = 3'b010,
        CC_LT     = 3'b011,
        CC_GTE    = 3'b100,
        CC_LTE    = 3'b101,
        CC_OVFL   = 3'b110,
        CC_UNCOND = 3'b111
    } ccc_t;

    typedef struct packed {
        logic n;
        logic z;
        logic v;
    } flags_t;

    // Opcode predicates as bit masks indexed by the 4-bit opcode.
    // SETS_ALL: ADD, SUB update N/Z/V.
    localparam logic [15:0] SETS_ALL = 16'b0000_0000_0000_0011;
    // SETS_Z: XOR, SLL, SRA, ROR update Z only.
    localparam logic [15:0] SETS_Z   = 16'b0000_0000_0111_0100;

    function automatic logic sets_all(input logic [3:0] op);
        return SETS_ALL[op];
    endfunction

    function automatic logic sets_z(input logic [3:0] op);
        return SETS_Z[op];
    endfunction

endpackage

// File: rtl/branch_cond.sv
// Branch condition evaluation from a flag set; shared with the ID-stage branch unit.
module branch_cond
    import wisc_pkg::*;
(
    input  flags_t flags,
    input  ccc_t   ccc,
    output logic   taken
);

    // Decode the condition code against the supplied flags.
    always_comb begin
        taken = 1'b0;
        unique case (ccc)
            CC_NEQ:    taken = ~flags.z;
            CC_EQ:     taken = flags.z;
            CC_GT:     taken = ~flags.z & ~flags.n;
            CC_LT:     taken = flags.n;
            CC_GTE:    taken = flags.z | (~flags.z & ~flags.n);
            CC_LTE:    taken = flags.n | flags.z;
            CC_OVFL:   taken = flags.v;
            CC_UNCOND: taken = 1'b1;
            default:   taken = 1'b0;
        endcase
    end

endmodule

// File: rtl/ex_flag_stage.sv
// EX/MEM result register, N/Z/V flag register, branch condition and flag hazard.
module ex_flag_stage
    import wisc_pkg::*;
#(
    parameter int unsigned DW  = wisc_pkg::DW,
    parameter int unsigned OPW = wisc_pkg::OPW
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            stall,
    input  logic            flush,
    input  logic            ex_valid,
    input  logic [OPW-1:0]  ex_opcode,
    input  logic [DW-1:0]   alu_result,
    input  logic            alu_ovfl,
    input  logic [2:0]      br_ccc,
    output logic [DW-1:0]   exmem_result,
    output logic            exmem_valid,
    output logic            flag_n,
    output logic            flag_z,
    output logic            flag_v,
    output logic            flag_busy,
    output logic            br_taken
);

    flags_t flags_q;
    flags_t flags_next;
    logic   op_all;
    logic   op_z;

    assign op_all = sets_all(4'(ex_opcode));
    assign op_z   = sets_z(4'(ex_opcode));

    // Next flag value for a normal-update cycle; squash and stall are handled at the register.
    always_comb begin
        flags_next = flags_q;
        if (ex_valid && op_all) begin
            flags_next.n = alu_result[DW-1];
            flags_next.z = (alu_result == '0);
            flags_next.v = alu_ovfl;
        end else if (ex_valid && op_z) begin
            flags_next.z = (alu_result == '0);
        end
    end

    // Pipeline and flag registers: rst > flush > stall > normal update.
    always_ff @(posedge clk) begin
        if (rst) begin
            exmem_result <= '0;
            exmem_valid  <= 1'b0;
            flags_q      <= '0;
        end else if (flush) begin
            exmem_result <= '0;
            exmem_valid  <= 1'b0;
        end else if (!stall) begin
            exmem_result <= alu_result;
            exmem_valid  <= ex_valid;
            flags_q      <= flags_next;
        end
    end

    assign flag_n    = flags_q.n;
    assign flag_z    = flags_q.z;
    assign flag_v    = flags_q.v;
    assign flag_busy = ex_valid & ~flush & (op_all | op_z);

    // Branches only ever see committed flags; the hazard unit stalls on flag_busy.
    branch_cond u_branch_cond (
        .flags (flags_q),
        .ccc   (ccc_t'(br_ccc)),
        .taken (br_taken)
    );

endmodule

// File: tb/tb_ex_flag_stage.sv
// Self-checking bench for ex_flag_stage: directed vector table then random vs. reference model.
module tb_ex_flag_stage;

    logic        clk = 1'b0;
    logic        rst, stall, flush, ex_valid, alu_ovfl;
    logic [3:0]  ex_opcode;
    logic [15:0] alu_result;
    logic [2:0]  br_ccc;
    logic [15:0] exmem_result;
    logic        exmem_valid, flag_n, flag_z, flag_v, flag_busy, br_taken;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    ex_flag_stage dut (
        .clk          (clk),
        .rst          (rst),
        .stall        (stall),
        .flush        (flush),
        .ex_valid     (ex_valid),
        .ex_opcode    (ex_opcode),
        .alu_result   (alu_result),
        .alu_ovfl     (alu_ovfl),
        .br_ccc       (br_ccc),
        .exmem_result (exmem_result),
        .exmem_valid  (exmem_valid),
        .flag_n       (flag_n),
        .flag_z       (flag_z),
        .flag_v       (flag_v),
        .flag_busy    (flag_busy),
        .br_taken     (br_taken)
    );

    // ctl = {rst, stall, flush, ex_valid}; e_nzv = {N, Z, V} after the edge.
    typedef struct {
        logic [3:0]  ctl;
        logic [3:0]  op;
        logic [15:0] res;
        logic        ovfl;
        logic [2:0]  ccc;
        logic        e_busy;
        logic [15:0] e_res;
        logic        e_val;
        logic [2:0]  e_nzv;
        logic        e_taken;
    } vec_t;

    vec_t vecs[17];

    // Reference model state
    logic [15:0] m_res;
    logic        m_val, m_n, m_z, m_v;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic logic model_taken(input logic [2:0] c, input logic n, input logic z, input logic v);
        int signed cmp;
        // Treat flags as the outcome of a compare: negative, zero or positive.
        cmp = z ? 0 : (n ? -1 : 1);
        case (c)
            3'd0: return cmp != 0;
            3'd1: return cmp == 0;
            3'd2: return cmp > 0;
            3'd3: return n;
            3'd4: return cmp >= 0;
            3'd5: return n || z;
            3'd6: return v;
            default: return 1'b1;
        endcase
    endfunction

    function automatic logic model_busy(input logic vld, input logic fl, input logic [3:0] op);
        return vld && !fl && (op inside {4'd0, 4'd1, 4'd2, 4'd4, 4'd5, 4'd6});
    endfunction

    task automatic drive(input logic [3:0] ctl, input logic [3:0] op, input logic [15:0] res,
                         input logic ovfl, input logic [2:0] ccc);
        {rst, stall, flush, ex_valid} = ctl;
        ex_opcode  = op;
        alu_result = res;
        alu_ovfl   = ovfl;
        br_ccc     = ccc;
    endtask

    initial begin
        vecs[0]  = '{4'b1000, 4'h0, 16'h0000, 1'b0, 3'b111, 1'b0, 16'h0000, 1'b0, 3'b000, 1'b1};
        vecs[1]  = '{4'b1000, 4'h0, 16'h0000, 1'b0, 3'b001, 1'b0, 16'h0000, 1'b0, 3'b000, 1'b0};
        vecs[2]  = '{4'b0001, 4'h0, 16'h7FFF, 1'b1, 3'b110, 1'b1, 16'h7FFF, 1'b1, 3'b001, 1'b1};
        vecs[3]  = '{4'b0001, 4'h1, 16'h0000, 1'b0, 3'b001, 1'b1, 16'h0000, 1'b1, 3'b010, 1'b1};
        vecs[4]  = '{4'b0001, 4'h7, 16'h17C8, 1'b0, 3'b001, 1'b0, 16'h17C8, 1'b1, 3'b010, 1'b1};
        vecs[5]  = '{4'b0001, 4'h0, 16'h8000, 1'b1, 3'b101, 1'b1, 16'h8000, 1'b1, 3'b101, 1'b1};
        vecs[6]  = '{4'b0001, 4'h2, 16'h0000, 1'b0, 3'b101, 1'b1, 16'h0000, 1'b1, 3'b111, 1'b1};
        vecs[7]  = '{4'b0101, 4'h1, 16'h8000, 1'b0, 3'b000, 1'b1, 16'h0000, 1'b1, 3'b111, 1'b0};
        vecs[8]  = '{4'b0111, 4'h1, 16'h8000, 1'b0, 3'b000, 1'b0, 16'h0000, 1'b0, 3'b111, 1'b0};
        vecs[9]  = '{4'b1001, 4'h0, 16'hAFFA, 1'b0, 3'b000, 1'b1, 16'h0000, 1'b0, 3'b000, 1'b1};
        vecs[10] = '{4'b0000, 4'h0, 16'h1234, 1'b0, 3'b010, 1'b0, 16'h1234, 1'b0, 3'b000, 1'b1};
        vecs[11] = '{4'b0001, 4'h4, 16'h0001, 1'b0, 3'b100, 1'b1, 16'h0001, 1'b1, 3'b000, 1'b1};
        vecs[12] = '{4'b0001, 4'h5, 16'hFFFF, 1'b0, 3'b011, 1'b1, 16'hFFFF, 1'b1, 3'b000, 1'b0};
        vecs[13] = '{4'b0001, 4'h8, 16'h0000, 1'b0, 3'b001, 1'b0, 16'h0000, 1'b1, 3'b000, 1'b0};
        vecs[14] = '{4'b0001, 4'h6, 16'h0000, 1'b0, 3'b001, 1'b1, 16'h0000, 1'b1, 3'b010, 1'b1};
        vecs[15] = '{4'b0001, 4'h3, 16'h8000, 1'b1, 3'b110, 1'b0, 16'h8000, 1'b1, 3'b010, 1'b0};
        vecs[16] = '{4'b0011, 4'h1, 16'h0000, 1'b0, 3'b111, 1'b0, 16'h0000, 1'b0, 3'b010, 1'b1};

        drive(4'b1000, 4'h0, 16'h0000, 1'b0, 3'b111);

        // Directed vectors: combinational busy before the edge, registers and taken after.
        for (int i = 0; i < 17; i++) begin
            drive(vecs[i].ctl, vecs[i].op, vecs[i].res, vecs[i].ovfl, vecs[i].ccc);
            #1;
            check($sformatf("vec%0d flag_busy", i), 32'(flag_busy), 32'(vecs[i].e_busy));
            @(posedge clk);
            #1;
            check($sformatf("vec%0d exmem_result", i), 32'(exmem_result), 32'(vecs[i].e_res));
            check($sformatf("vec%0d exmem_valid", i), 32'(exmem_valid), 32'(vecs[i].e_val));
            check($sformatf("vec%0d nzv", i), 32'({flag_n, flag_z, flag_v}), 32'(vecs[i].e_nzv));
            check($sformatf("vec%0d br_taken", i), 32'(br_taken), 32'(vecs[i].e_taken));
        end

        // Model continues from the last directed vector's expected state.
        m_res = vecs[16].e_res;
        m_val = vecs[16].e_val;
        {m_n, m_z, m_v} = vecs[16].e_nzv;

        // Randomized phase against the reference model.
        for (int i = 0; i < 400; i++) begin
            logic [3:0]  ctl;
            logic [3:0]  op;
            logic [15:0] res;
            logic        ov;
            logic [2:0]  cc;
            ctl[3] = ($urandom_range(0, 31) == 0);
            ctl[2] = ($urandom_range(0, 3) == 0);
            ctl[1] = ($urandom_range(0, 5) == 0);
            ctl[0] = ($urandom_range(0, 4) != 0);
            op  = 4'($urandom_range(0, 15));
            res = ($urandom_range(0, 3) == 0) ? 16'h0000 : 16'($urandom);
            ov  = 1'($urandom_range(0, 1));
            cc  = 3'($urandom_range(0, 7));
            drive(ctl, op, res, ov, cc);
            #1;
            check("rand flag_busy", 32'(flag_busy), 32'(model_busy(ctl[0], ctl[1], op)));
            check("rand br_taken pre", 32'(br_taken), 32'(model_taken(cc, m_n, m_z, m_v)));
            @(posedge clk);
            if (ctl[3]) begin
                m_res = 16'h0000; m_val = 1'b0; m_n = 1'b0; m_z = 1'b0; m_v = 1'b0;
            end else if (ctl[1]) begin
                m_res = 16'h0000; m_val = 1'b0;
            end else if (!ctl[2]) begin
                m_res = res;
                m_val = ctl[0];
                if (ctl[0] && op <= 4'd1) begin
                    m_n = res[15];
                    m_z = (res == 16'h0000);
                    m_v = ov;
                end else if (ctl[0] && (op inside {4'd2, 4'd4, 4'd5, 4'd6})) begin
                    m_z = (res == 16'h0000);
                end
            end
            #1;
            check("rand exmem_result", 32'(exmem_result), 32'(m_res));
            check("rand exmem_valid", 32'(exmem_valid), 32'(m_val));
            check("rand nzv", 32'({flag_n, flag_z, flag_v}), 32'({m_n, m_z, m_v}));
            check("rand br_taken", 32'(br_taken), 32'(model_taken(cc, m_n, m_z, m_v)));
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/ex_flag_stage.md
Name: ex_flag_stage

Overview:
- Sits directly downstream of the EX-stage ALU, which contains the parallel saturating nibble adder (PADDSB), ADD/SUB, XOR, RED and the shifters.
- Latches the ALU result into the EX/MEM pipeline register and maintains the architectural N/Z/V flag register under the WISC flag-update rules.
- Evaluates branch conditions for the ID stage from the committed flags.
- Raises a flag-hazard indication so the hazard unit can stall a dependent branch.

Parameters:
- DW, 16, datapath width of ALU result and EX/MEM result register.
- OPW, 4, opcode width.

Ports:
- clk  input  1  system clock, all state updates on rising edge.
- rst  input  1  synchronous, active-high reset.
- stall  input  1  hold all state; EX/MEM register and flags keep their values.
- flush  input  1  squash the instruction currently in EX.
- ex_valid  input  1  EX holds a real instruction this cycle.
- ex_opcode  input  OPW  opcode of the EX instruction.
- alu_result  input  DW  ALU output; already saturated for ADD/SUB/PADDSB.
- alu_ovfl  input  1  ALU signed-overflow (saturation) indication for ADD/SUB.
- br_ccc  input  3  condition code of the branch currently in ID.
- exmem_result  output  DW  registered ALU result.
- exmem_valid  output  1  registered valid for exmem_result.
- flag_n, flag_z, flag_v  output  1 each  committed flag register.
- flag_busy  output  1  combinational; EX holds a valid, unflushed, flag-setting instruction.
- br_taken  output  1  combinational condition result from the committed flags.

Behaviour:
- Reset: when rst=1 at the clock edge:
  - exmem_result = 0, exmem_valid = 0.
  - flag_n = 0, flag_z = 0, flag_v = 0.
- Priority at each edge: rst > flush > stall > normal update.
- Normal update (no rst/flush/stall):
  - exmem_result <= alu_result; exmem_valid <= ex_valid. Latency is 1 cycle.
- Flush:
  - exmem_valid <= 0; exmem_result <= 0.
  - Flags unchanged, even if the squashed opcode would set flags.
  - Flush overrides a simultaneous stall.
- Stall (without flush): every register holds its value; flags do not update.
- Flag update applies only on a normal-update cycle with ex_valid=1. Opcode rules:
  - ADD 0000, SUB 0001: update N, Z and V.
    - N = alu_result[DW-1].
    - Z = (alu_result == 0).
    - V = alu_ovfl.
  - XOR 0010, SLL 0100, SRA 0101, ROR 0110: update Z only; N and V hold.
  - RED 0011, PADDSB 0111, and every opcode >= 1000: no flag change.
- flag_busy = ex_valid & ~flush & (opcode in {ADD, SUB, XOR, SLL, SRA, ROR}).
  - The hazard unit stalls a branch in ID while flag_busy=1.
  - br_taken never forwards uncommitted flags.
- br_taken, decoded from the committed flags only:
  - 000 NEQ: ~Z
  - 001 EQ: Z
  - 010 GT: ~Z & ~N
  - 011 LT: N
  - 100 GTE: Z | (~Z & ~N)
  - 101 LTE: N | Z
  - 110 OVFL: V
  - 111 UNCOND: 1
- Result width: alu_result is passed through unmodified. No arithmetic is performed here.
- Reset mid-stall or mid-flush: reset wins; all outputs return to their reset values on that edge.

Decomposition:
- Shared package wisc_pkg:
  - opcode_t enum (4-bit, values above).
  - ccc_t enum (3-bit, values above).
  - flags_t packed struct {n, z, v}.
  - Helper constants SETS_ALL / SETS_Z as opcode predicates.
- One sub-module, branch_cond: purely combinational flags_t + ccc_t -> taken. It is reused by the ID-stage branch unit.

Test Plan:
- Reset then idle: rst=1 for 2 cycles -> exmem_valid=0, exmem_result=0000, N/Z/V=0; br_ccc=111 -> br_taken=1, br_ccc=001 -> br_taken=0.
- ADD overflow: ex_opcode=ADD, alu_result=7FFF, alu_ovfl=1 -> next cycle exmem_result=7FFF, N=0, Z=0, V=1; br_ccc=110 -> br_taken=1; flag_busy=1 during the EX cycle.
- PADDSB leaves flags: after SUB with alu_result=0000 (Z=1, N=0, V=0), issue PADDSB with alu_result=17C8 -> exmem_result=17C8, flags still Z=1; br_ccc=001 -> br_taken=1; flag_busy=0.
- XOR partial update: flags N=1, V=1, then XOR with alu_result=0000 -> Z=1, N=1, V=1 unchanged; br_ccc=101 -> br_taken=1.
- Stall/flush interplay:
  - SUB with alu_result=8000 and stall=1 -> registers and flags hold.
  - The same cycle with flush=1 and stall=1 -> exmem_valid=0, N unchanged.
- Reset during activity: ADD result AFFA with rst=1 on the same edge -> exmem_result=0000, flags 0, exmem_valid=0.
